branch_gshare_predictor: RTL and testbench

- Parametrised direction predictor for the sail core fetch/decode path.
- Table of saturating counters, indexed either by PC alone (bimodal) or by PC XOR global history (gshare).
- Produces a combinational taken-prediction and branch target, and is trained once per resolved branch from the MEM stage.
- Keeps saturating statistics counters for resolved branches and mispredictions.

---
 rtl/branch_gshare_predictor.sv | 90 +++++++++
 tb/tb_branch_gshare_predictor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/branch_gshare_predictor.sv
// Branch direction predictor: a flop-based table of saturating counters indexed by
// PC (bimodal) or PC XOR committed global history (gshare), with resolved/mispredict statistics.
module branch_gshare_predictor #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 4,
    parameter int MODE       = 1,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_decode_sig,
    input  logic [ADDR_WIDTH-1:0] pc_branch_addr,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic                  branch_mem_sig,
    input  logic                  actual_branch_decision,
    input  logic [ADDR_WIDTH-1:0] update_branch_addr,
    output logic                  prediction,
    output logic [ADDR_WIDTH-1:0] out_branch_addr,
    output logic [GHR_BITS-1:0]   ghr,
    output logic [STAT_BITS-1:0]  stat_branches,
    output logic [STAT_BITS-1:0]  stat_mispredicts
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic [CTR_BITS-1:0]   ctr_tbl [DEPTH];
    logic [GHR_BITS-1:0]   ghr_q;
    logic                  mem_q;
    logic [STAT_BITS-1:0]  stat_br_q;
    logic [STAT_BITS-1:0]  stat_mp_q;

    logic                  upd;
    logic [INDEX_BITS-1:0] hist;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [CTR_BITS-1:0]   upd_ctr;
    logic [CTR_BITS-1:0]   ctr_next;
    logic                  mispredict;
    logic [GHR_BITS-1:0]   ghr_next;
    logic                  unused_addr_bits;

    assign upd = branch_mem_sig & ~mem_q;

    always_comb begin
        hist       = (MODE != 0) ? INDEX_BITS'(ghr_q) : '0;
        lookup_idx = pc_branch_addr[INDEX_BITS+1:2] ^ hist;
        upd_idx    = update_branch_addr[INDEX_BITS+1:2] ^ hist;
        upd_ctr    = ctr_tbl[upd_idx];
        ctr_next   = upd_ctr;
        if (actual_branch_decision) begin
            if (upd_ctr != '1) ctr_next = upd_ctr + CTR_BITS'(1);
        end else begin
            if (upd_ctr != '0) ctr_next = upd_ctr - CTR_BITS'(1);
        end
        mispredict = upd_ctr[CTR_BITS-1] != actual_branch_decision;
        // Truncating the concatenation drops the oldest bit; also covers GHR_BITS == 1.
        ghr_next   = GHR_BITS'({ghr_q, actual_branch_decision});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= CTR_WEAK;
            ghr_q     <= '0;
            mem_q     <= 1'b0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            mem_q <= branch_mem_sig;
            if (upd) begin
                ctr_tbl[upd_idx] <= ctr_next;
                ghr_q            <= ghr_next;
                if (stat_br_q != '1) stat_br_q <= stat_br_q + STAT_BITS'(1);
                if (mispredict && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + STAT_BITS'(1);
            end
        end
    end

    assign prediction       = ctr_tbl[lookup_idx][CTR_BITS-1] & branch_decode_sig;
    assign out_branch_addr  = pc_branch_addr + offset;
    assign ghr              = ghr_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    // Only the index field of each address feeds the table.
    assign unused_addr_bits = ^{pc_branch_addr, update_branch_addr};

endmodule

// File: tb/tb_branch_gshare_predictor.sv
// Directed bench for branch_gshare_predictor: one gshare and one bimodal instance share stimulus.
module tb_branch_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_decode_sig = 1'b0;
    logic [31:0] pc_branch_addr = '0;
    logic [31:0] offset = '0;
    logic        branch_mem_sig = 1'b0;
    logic        actual_branch_decision = 1'b0;
    logic [31:0] update_branch_addr = '0;

    logic        pred_g, pred_b;
    logic [31:0] tgt_g, tgt_b;
    logic [3:0]  ghr_g, ghr_b;
    logic [15:0] sb_g, sb_b, sm_g, sm_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_gshare_predictor #(.MODE(1)) u_gshare (
        .clk(clk), .reset(reset),
        .branch_decode_sig(branch_decode_sig), .pc_branch_addr(pc_branch_addr), .offset(offset),
        .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
        .update_branch_addr(update_branch_addr),
        .prediction(pred_g), .out_branch_addr(tgt_g), .ghr(ghr_g),
        .stat_branches(sb_g), .stat_mispredicts(sm_g)
    );

    branch_gshare_predictor #(.MODE(0)) u_bimodal (
        .clk(clk), .reset(reset),
        .branch_decode_sig(branch_decode_sig), .pc_branch_addr(pc_branch_addr), .offset(offset),
        .branch_mem_sig(branch_mem_sig), .actual_branch_decision(actual_branch_decision),
        .update_branch_addr(update_branch_addr),
        .prediction(pred_b), .out_branch_addr(tgt_b), .ghr(ghr_b),
        .stat_branches(sb_b), .stat_mispredicts(sm_b)
    );

    typedef struct {
        logic        dec;
        logic [31:0] pc;
        logic [31:0] off;
        logic        exp_pred;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] addr, input logic taken);
        @(negedge clk);
        branch_mem_sig         = 1'b1;
        update_branch_addr     = addr;
        actual_branch_decision = taken;
        @(negedge clk);
        branch_mem_sig = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        branch_decode_sig = 1'b1;
        pc_branch_addr    = pc;
        offset            = 32'h0;
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 1'b1, 32'h0000_00F0};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0000_0010, 1'b0, 32'h0000_0110};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1, 32'h0000_0004};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000};

        do_reset();

        // Post-reset lookups: all counters weakly taken.
        for (int i = 0; i < 5; i++) begin
            branch_decode_sig = vecs[i].dec;
            pc_branch_addr    = vecs[i].pc;
            offset            = vecs[i].off;
            #1;
            check($sformatf("vec%0d pred_g", i), 32'(pred_g), 32'(vecs[i].exp_pred));
            check($sformatf("vec%0d pred_b", i), 32'(pred_b), 32'(vecs[i].exp_pred));
            check($sformatf("vec%0d tgt", i), tgt_g, vecs[i].exp_tgt);
        end
        check("reset ghr", 32'(ghr_g), 32'h0);
        check("reset stat_br", 32'(sb_g), 32'h0);
        check("reset stat_mp", 32'(sm_g), 32'h0);

        // Three not-taken resolutions of 0x100: counter 2->1->0->0.
        pulse(32'h100, 1'b0);
        pulse(32'h100, 1'b0);
        pulse(32'h100, 1'b0);
        lookup(32'h100);
        check("nt3 pred_b", 32'(pred_b), 32'h0);
        check("nt3 pred_g", 32'(pred_g), 32'h0);
        check("nt3 stat_br", 32'(sb_b), 32'd3);
        check("nt3 stat_mp", 32'(sm_b), 32'd1);
        check("nt3 ghr", 32'(ghr_g), 32'h0);

        // Level held high five cycles trains exactly once.
        do_reset();
        @(negedge clk);
        branch_mem_sig         = 1'b1;
        update_branch_addr     = 32'h104;
        actual_branch_decision = 1'b1;
        repeat (5) @(negedge clk);
        branch_mem_sig = 1'b0;
        #1;
        check("hold stat_br", 32'(sb_g), 32'd1);
        check("hold stat_mp", 32'(sm_g), 32'd0);
        check("hold ghr", 32'(ghr_g), 32'h1);
        // Further taken pulses must saturate at 3, not wrap.
        pulse(32'h104, 1'b1);
        pulse(32'h104, 1'b1);
        lookup(32'h104);
        check("sat pred_b", 32'(pred_b), 32'h1);
        check("sat stat_br", 32'(sb_b), 32'd3);
        check("sat ghr", 32'(ghr_g), 32'h7);

        // gshare aliasing on index 7.
        do_reset();
        pulse(32'h1C, 1'b0);
        lookup(32'h1C);
        check("alias 1C pred_g", 32'(pred_g), 32'h0);
        check("alias 1C pred_b", 32'(pred_b), 32'h0);
        pulse(32'h0, 1'b1);
        pulse(32'h0, 1'b1);
        lookup(32'h10);
        check("alias ghr", 32'(ghr_g), 32'h3);
        check("alias 10 pred_g", 32'(pred_g), 32'h0);
        check("alias 10 pred_b", 32'(pred_b), 32'h1);
        lookup(32'h1C);
        check("alias 1C idx4 pred_g", 32'(pred_g), 32'h1);
        pulse(32'h10, 1'b1);
        lookup(32'h0);
        check("train7 ghr", 32'(ghr_g), 32'h7);
        check("train7 pred_g", 32'(pred_g), 32'h1);
        check("train7 stat_br", 32'(sb_g), 32'd4);
        check("train7 stat_mp", 32'(sm_g), 32'd2);

        // Asynchronous reset mid-cycle clears everything before any clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        lookup(32'h1C);
        check("async ghr", 32'(ghr_g), 32'h0);
        check("async stat_br", 32'(sb_g), 32'h0);
        check("async stat_mp", 32'(sm_g), 32'h0);
        check("async pred_g", 32'(pred_g), 32'h1);
        check("async pred_b", 32'(pred_b), 32'h1);
        @(negedge clk);
        reset = 1'b0;

        // Same-cycle lookup and update of entry 5.
        @(negedge clk);
        branch_decode_sig      = 1'b1;
        pc_branch_addr         = 32'h14;
        branch_mem_sig         = 1'b1;
        update_branch_addr     = 32'h14;
        actual_branch_decision = 1'b0;
        #1;
        check("same-cycle old pred_g", 32'(pred_g), 32'h1);
        check("same-cycle old pred_b", 32'(pred_b), 32'h1);
        @(posedge clk);
        #1;
        check("same-cycle new pred_g", 32'(pred_g), 32'h0);
        check("same-cycle new pred_b", 32'(pred_b), 32'h0);
        @(negedge clk);
        branch_mem_sig = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
